sacc_datapath: RTL and testbench

SACC_DATAPATH -- requirements
Module: sacc_datapath

---
 rtl/sacc_datapath.sv | 163 ++++++++++++++++
 tb/tb_sacc_datapath.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sacc_datapath.sv
// sacc_datapath: single-accumulator datapath with an NREG-entry register file.
// Every instruction walks IDLE -> READ -> EXEC -> WRITE -> IDLE, one state per
// cycle; Done pulses in the IDLE cycle that follows WRITE.
// Optional feature macro: SACC_SAT_EN (saturating ADDA/SUBA on signed overflow).
// Handshake: Ready is high exactly in IDLE; a Start seen high at a rising edge
// while Ready is high is accepted and IRData is captured on that edge; Start in
// any other state is ignored.
module sacc_datapath #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] IRData,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] AccOut,
    output logic [WIDTH-1:0] BOut,
    output logic [WIDTH-1:0] COut,
    output logic             Ovf
);
    localparam int ADDR = $clog2(NREG);

    localparam logic [3:0] OP_SACC = 4'hF;
    localparam logic [3:0] OP_LACC = 4'hE;
    localparam logic [3:0] OP_ADDA = 4'hD;
    localparam logic [3:0] OP_SUBA = 4'hC;
    localparam logic [3:0] OP_LIMM = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] bout_q, bout_d;
    logic [WIDTH-1:0] cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ovf_pend_q, ovf_pend_d;   // overflow computed in EXEC, committed in WRITE
    logic             done_q, done_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];

    // Instruction fields, always taken from the captured IR
    logic [3:0]       opcode;
    logic [ADDR-1:0]  reg_idx;
    logic [WIDTH-1:0] imm_ext;
    assign opcode  = ir_q[WIDTH-1 -: 4];
    assign reg_idx = ir_q[WIDTH-5 -: ADDR];
    assign imm_ext = {4'h0, ir_q[WIDTH-5:0]};

    // Modulo arithmetic on Acc and the latched operand, with signed overflow
    logic [WIDTH-1:0] sum, diff, add_res, sub_res;
    logic             add_ovf, sub_ovf;
    assign sum     = acc_q + bout_q;
    assign diff    = acc_q - bout_q;
    assign add_ovf = (acc_q[WIDTH-1] == bout_q[WIDTH-1]) && (sum[WIDTH-1]  != acc_q[WIDTH-1]);
    assign sub_ovf = (acc_q[WIDTH-1] != bout_q[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);

`ifdef SACC_SAT_EN
    // On overflow the true result lies beyond the limit on the side of Acc's sign
    logic [WIDTH-1:0] sat_val;
    assign sat_val = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign add_res = add_ovf ? sat_val : sum;
    assign sub_res = sub_ovf ? sat_val : diff;
`else
    assign add_res = sum;
    assign sub_res = diff;
`endif

    // Next-state and datapath update for the four-phase instruction sequence
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        bout_d     = bout_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        rf_d       = rf_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    ir_d    = IRData;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                bout_d  = rf_q[reg_idx];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_SACC: cout_d = acc_q;
                    OP_LACC: cout_d = bout_q;
                    OP_ADDA: begin
                        cout_d     = add_res;
                        ovf_pend_d = add_ovf;
                    end
                    OP_SUBA: begin
                        cout_d     = sub_res;
                        ovf_pend_d = sub_ovf;
                    end
                    OP_LIMM: cout_d = imm_ext;
                    default: ;
                endcase
                state_d = S_WRITE;
            end
            S_WRITE: begin
                case (opcode)
                    OP_SACC: rf_d[reg_idx] = cout_q;
                    OP_LACC, OP_LIMM: acc_d = cout_q;
                    OP_ADDA, OP_SUBA: begin
                        acc_d = cout_q;
                        ovf_d = ovf_pend_q;
                    end
                    default: ;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any instruction in flight
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            acc_q      <= '0;
            bout_q     <= '0;
            cout_q     <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            acc_q      <= acc_d;
            bout_q     <= bout_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign Ready  = (state_q == S_IDLE);
    assign Done   = done_q;
    assign AccOut = acc_q;
    assign BOut   = bout_q;
    assign COut   = cout_q;
    assign Ovf    = ovf_q;
endmodule

// File: tb/tb_sacc_datapath.sv
// Testbench for sacc_datapath (WIDTH=16, NREG=8): directed scenarios plus
// randomized instruction streams against a behavioural model.
module tb_sacc_datapath;
    localparam int W = 16;
    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] IRData;
    logic         Ready, Done, Ovf;
    logic [W-1:0] AccOut, BOut, COut;

    sacc_datapath #(.WIDTH(W), .NREG(N)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .IRData(IRData),
        .Ready(Ready), .Done(Done), .AccOut(AccOut), .BOut(BOut),
        .COut(COut), .Ovf(Ovf)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Hard time limit
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_acc, m_b, m_c;
    logic         m_ovf;
    logic [W-1:0] m_rf [N];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_b = '0; m_c = '0; m_ovf = 1'b0;
        for (int i = 0; i < N; i++) m_rf[i] = '0;
    endtask

    // Architectural effect of one instruction, from the opcode table
    task automatic model_step(input logic [W-1:0] ir);
        logic [3:0]   op;
        int           r, sa, sb, s;
        logic [W-1:0] imm;
        op  = ir[15:12];
        r   = int'(ir[11:9]);
        imm = {4'h0, ir[11:0]};
        m_b = m_rf[r];
        case (op)
            4'hF: begin m_c = m_acc; m_rf[r] = m_acc; end
            4'hE: begin m_c = m_b; m_acc = m_b; end
            4'hD, 4'hC: begin
                sa = int'($signed(m_acc));
                sb = int'($signed(m_b));
                s  = (op == 4'hD) ? sa + sb : sa - sb;
                m_ovf = (s > 32767) || (s < -32768);
`ifdef SACC_SAT_EN
                if (m_ovf) m_c = (s > 0) ? 16'h7FFF : 16'h8000;
                else       m_c = s[15:0];
`else
                m_c = s[15:0];
`endif
                m_acc = m_c;
            end
            4'hB: begin m_c = imm; m_acc = imm; end
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s_r%0d", tag, i), dut.rf_q[i], m_rf[i]);
    endtask

    // Driver: issue one instruction at a negedge and follow it through all phases
    task automatic exec(input logic [W-1:0] ir, input string tag);
        int n = 0;
        while (Ready !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ready"}, {15'b0, Ready}, 16'd1);
        Start  = 1'b1;
        IRData = ir;
        model_step(ir);
        @(negedge CLK);                       // READ
        Start  = 1'b0;
        IRData = 16'($urandom);
        chk({tag, "_busy"}, {15'b0, Ready}, 16'd0);
        chk({tag, "_nodone_r"}, {15'b0, Done}, 16'd0);
        @(negedge CLK);                       // EXEC
        chk({tag, "_bout"}, BOut, m_b);
        chk({tag, "_nodone_e"}, {15'b0, Done}, 16'd0);
        @(negedge CLK);                       // WRITE
        chk({tag, "_cout"}, COut, m_c);
        chk({tag, "_nodone_w"}, {15'b0, Done}, 16'd0);
        @(negedge CLK);                       // IDLE with Done
        chk({tag, "_done"}, {15'b0, Done}, 16'd1);
        chk({tag, "_acc"}, AccOut, m_acc);
        chk({tag, "_ovf"}, {15'b0, Ovf}, {15'b0, m_ovf});
    endtask

    logic [W-1:0] bb [3];
    logic [3:0]   rop;
    int           sel;
    logic [2:0]   rr;

    initial begin
        // Reset
        Reset = 1'b1; Start = 1'b0; IRData = '0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        model_reset();
        chk("rst_ready", {15'b0, Ready}, 16'd1);
        chk("rst_done", {15'b0, Done}, 16'd0);
        chk("rst_acc", AccOut, 16'h0000);
        chk("rst_bout", BOut, 16'h0000);
        chk("rst_cout", COut, 16'h0000);
        chk("rst_ovf", {15'b0, Ovf}, 16'd0);
        check_regs("rst");

        // LIMM, SACC, LIMM 0, LACC round trip
        exec(16'hB123, "limm");
        chk("limm_const", AccOut, 16'h0123);
        exec(16'hF000, "sacc0");
        chk("sacc0_const", COut, 16'h0123);
        exec(16'hB000, "limm0");
        exec(16'hE000, "lacc0");
        chk("lacc0_const", AccOut, 16'h0123);

        // Doubling through R1 until signed overflow
        exec(16'hB800, "ov_limm");
        repeat (3) begin
            exec(16'hF200, "ov_sacc");
            exec(16'hD200, "ov_adda");
        end
        chk("ov_pre_acc", AccOut, 16'h4000);
        exec(16'hF200, "ov_sacc");
        exec(16'hD200, "ov_adda");
`ifdef SACC_SAT_EN
        chk("ov_const_acc", AccOut, 16'h7FFF);
`else
        chk("ov_const_acc", AccOut, 16'h8000);
`endif
        chk("ov_const_flag", {15'b0, Ovf}, 16'd1);
        // Ovf holds across non-arithmetic opcodes
        exec(16'hB005, "ov_hold");
        chk("ov_hold_flag", {15'b0, Ovf}, 16'd1);

        // NOP leaves everything but Done alone
        exec(16'h1000, "nop");
        check_regs("nop");

        // Start held high across three instructions
        rr    = 3'($urandom);
        bb[0] = {4'hB, 12'($urandom)};
        bb[1] = {4'hF, rr, 9'($urandom)};
        bb[2] = {4'hD, rr, 9'($urandom)};
        Start = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k == 12) begin
                Start = 1'b0;
                chk("b2b_ready_end", {15'b0, Ready}, 16'd1);
                chk("b2b_done_end", {15'b0, Done}, 16'd1);
                chk("b2b_acc", AccOut, m_acc);
            end else begin
                if (k % 4 == 0) begin
                    chk($sformatf("b2b_ready_%0d", k), {15'b0, Ready}, 16'd1);
                    IRData = bb[k/4];
                    model_step(bb[k/4]);
                end else begin
                    chk($sformatf("b2b_busy_%0d", k), {15'b0, Ready}, 16'd0);
                    IRData = 16'($urandom);
                end
                if (k > 0)
                    chk($sformatf("b2b_done_%0d", k), {15'b0, Done}, {15'b0, (k % 4 == 0)});
                @(negedge CLK);
            end
        end
        check_regs("b2b");

        // Randomized instruction stream
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: rop = 4'hF;
                1: rop = 4'hE;
                2: rop = 4'hD;
                3: rop = 4'hC;
                4: rop = 4'hB;
                default: rop = 4'($urandom_range(0, 10));
            endcase
            exec({rop, 12'($urandom)}, $sformatf("rnd%0d", t));
        end
        check_regs("rnd");

        // Reset while an ADDA sits in EXEC
        exec(16'hB7FF, "ab_limm");
        exec(16'hF400, "ab_sacc");
        Start = 1'b1; IRData = 16'hD400;
        @(negedge CLK);                       // READ
        Start = 1'b0;
        @(negedge CLK);                       // EXEC
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        model_reset();
        chk("ab_nodone", {15'b0, Done}, 16'd0);
        chk("ab_ready", {15'b0, Ready}, 16'd1);
        chk("ab_acc", AccOut, 16'h0000);
        chk("ab_cout", COut, 16'h0000);
        chk("ab_ovf", {15'b0, Ovf}, 16'd0);
        check_regs("ab");
        @(negedge CLK);
        chk("ab_ready_next", {15'b0, Ready}, 16'd1);
        chk("ab_nodone_next", {15'b0, Done}, 16'd0);
        exec(16'hE400, "ab_lacc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
